// File: rtl/mem_stage_pkg.sv
// Shared definitions for the pipeline stages: default widths, the stage
// FSM encoding and small decode helpers.
package mem_stage_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_REG_W       = 5;
  localparam int DEF_ACK_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PASS   = 2'd1,
    ST_ACCESS = 2'd2
  } stage_state_e;

  // An instruction needs the data memory when it reads or writes it.
  function automatic logic is_mem_op(input logic mem_read, input logic mem_write);
    return mem_read | mem_write;
  endfunction

  // Width of a counter that must reach max_count (never narrower than 1 bit).
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master)
// and the data memory (slave).
interface mem_stage_if import mem_stage_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage_stage_reg.sv
// Generic pipeline register with load enable and synchronous clear,
// used for both the EX/MEM and MEM/WB registers.
module stage_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  // Clear on reset or request, load when enabled, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_q <= {W{1'b0}};
    end else if (i_en) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/mem_stage.sv
// Memory stage: latches EX results, redirects IF on taken branches,
// performs loads/stores over the dmem handshake (with optional timeout)
// and feeds the MEM/WB register.
module mem_stage import mem_stage_pkg::*; #(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int REG_W       = DEF_REG_W,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_ex_valid,
  input  logic [DATA_W-1:0] i_ex_alu_out,
  input  logic [DATA_W-1:0] i_ex_write_data,
  input  logic [REG_W-1:0]  i_ex_rd,
  input  logic              i_ex_branch,
  input  logic [DATA_W-1:0] i_ex_branch_target,
  input  logic              i_ex_mem_read,
  input  logic              i_ex_mem_write,
  input  logic              i_ex_reg_write,
  input  logic              i_ex_mem_to_reg,
  output logic              o_stall_out,
  output logic              o_pc_src,
  output logic [DATA_W-1:0] o_branch_target,
  mem_stage_if.master       dmem,
  output logic              o_wb_valid,
  output logic              o_wb_reg_write,
  output logic [REG_W-1:0]  o_wb_rd,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_mem_err
);
  // EX/MEM layout, LSB first: mem_to_reg, reg_write, mem_write, rd, target, wdata, alu
  localparam int OFF_RW  = 1;
  localparam int OFF_MW  = 2;
  localparam int OFF_RD  = 3;
  localparam int OFF_TGT = OFF_RD + REG_W;
  localparam int OFF_WD  = OFF_TGT + DATA_W;
  localparam int OFF_ALU = OFF_WD + DATA_W;
  localparam int EXM_W   = OFF_ALU + DATA_W;
  localparam int MWB_W   = 1 + REG_W + DATA_W;

  localparam int               CNT_W   = cnt_width(ACK_TIMEOUT);
  localparam bit               TO_EN   = (ACK_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  stage_state_e      r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_dmem_req;
  logic              r_dmem_we;
  logic              r_pc_src;
  logic              r_mem_err;
  logic              r_wb_valid;

  logic [EXM_W-1:0]  w_exm_d;
  logic [EXM_W-1:0]  w_exm_q;
  logic [MWB_W-1:0]  w_mwb_d;
  logic [MWB_W-1:0]  w_mwb_q;

  logic              w_stall;
  logic              w_accept;
  logic              w_timeout;
  logic              w_retire;
  stage_state_e      w_seq_state;
  stage_state_e      w_next_state;
  logic [CNT_W-1:0]  w_seq_cnt;
  logic [CNT_W-1:0]  w_next_cnt;
  logic              w_seq_we;
  logic              w_next_we;

  logic [DATA_W-1:0] w_m_alu;
  logic [DATA_W-1:0] w_m_wdata;
  logic [DATA_W-1:0] w_m_tgt;
  logic [REG_W-1:0]  w_m_rd;
  logic              w_m_mem_write;
  logic              w_m_reg_write;
  logic              w_m_mem_to_reg;

  assign w_exm_d = {i_ex_alu_out, i_ex_write_data, i_ex_branch_target, i_ex_rd,
                    i_ex_mem_write, i_ex_reg_write, i_ex_mem_to_reg};

  assign w_m_alu        = w_exm_q[OFF_ALU +: DATA_W];
  assign w_m_wdata      = w_exm_q[OFF_WD  +: DATA_W];
  assign w_m_tgt        = w_exm_q[OFF_TGT +: DATA_W];
  assign w_m_rd         = w_exm_q[OFF_RD  +: REG_W];
  assign w_m_mem_write  = w_exm_q[OFF_MW];
  assign w_m_reg_write  = w_exm_q[OFF_RW];
  assign w_m_mem_to_reg = w_exm_q[0];

  // Upstream holds only while an access is outstanding and not acked this cycle.
  assign w_stall   = (r_state == ST_ACCESS) & ~dmem.ack;
  assign w_accept  = i_ex_valid & ~w_stall;
  assign w_timeout = TO_EN & w_stall & (r_cnt == TO_LAST);

  stage_reg #(.W(EXM_W)) u_ex_mem (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_accept),
    .i_clr (1'b0),
    .i_d   (w_exm_d),
    .o_q   (w_exm_q)
  );

  // Decide retirement, MEM/WB contents and where the held instruction goes next.
  always_comb begin
    w_retire    = 1'b0;
    w_mwb_d     = {1'b0, w_m_rd, w_m_alu};
    w_seq_state = ST_IDLE;
    w_seq_cnt   = {CNT_W{1'b0}};
    w_seq_we    = 1'b0;
    case (r_state)
      ST_PASS: begin
        w_retire = 1'b1;
        w_mwb_d  = {w_m_reg_write, w_m_rd, w_m_alu};
      end
      ST_ACCESS: begin
        if (dmem.ack) begin
          // Ack wins even on the timeout cycle; a store never writes a register.
          w_retire = 1'b1;
          w_mwb_d  = {w_m_reg_write & w_m_mem_to_reg & ~w_m_mem_write, w_m_rd,
                      w_m_mem_write ? w_m_alu : dmem.rdata};
        end else if (w_timeout) begin
          w_retire = 1'b1;
          w_mwb_d  = {1'b0, w_m_rd, w_m_alu};
        end else begin
          w_seq_state = ST_ACCESS;
          w_seq_cnt   = r_cnt + CNT_W'(1);
          w_seq_we    = w_m_mem_write;
        end
      end
      default: begin
        w_retire = 1'b0;
      end
    endcase
  end

  assign w_next_state = w_accept ? (is_mem_op(i_ex_mem_read, i_ex_mem_write) ? ST_ACCESS : ST_PASS)
                                 : w_seq_state;
  assign w_next_cnt   = w_accept ? {CNT_W{1'b0}} : w_seq_cnt;
  assign w_next_we    = w_accept ? i_ex_mem_write : w_seq_we;

  stage_reg #(.W(MWB_W)) u_mem_wb (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_retire),
    .i_clr (1'b0),
    .i_d   (w_mwb_d),
    .o_q   (w_mwb_q)
  );

  // Stage FSM with registered request, redirect, error and retire flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_pc_src   <= 1'b0;
      r_mem_err  <= 1'b0;
      r_wb_valid <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_dmem_req <= (w_next_state == ST_ACCESS);
      r_dmem_we  <= (w_next_state == ST_ACCESS) & w_next_we;
      r_pc_src   <= w_accept & i_ex_branch;
      r_mem_err  <= w_timeout;
      r_wb_valid <= w_retire;
    end
  end

  assign o_stall_out     = w_stall;
  assign o_pc_src        = r_pc_src;
  assign o_branch_target = w_m_tgt;
  assign dmem.req        = r_dmem_req;
  assign dmem.we         = r_dmem_we;
  assign dmem.addr       = w_m_alu;
  assign dmem.wdata      = w_m_wdata;
  assign o_wb_valid      = r_wb_valid;
  assign o_wb_reg_write  = w_mwb_q[MWB_W-1];
  assign o_wb_rd         = w_mwb_q[DATA_W +: REG_W];
  assign o_wb_data       = w_mwb_q[DATA_W-1:0];
  assign o_mem_err       = r_mem_err;
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (ACK_TIMEOUT = 4).
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [31:0] ex_alu_out, ex_write_data, ex_branch_target;
  logic [4:0]  ex_rd;
  logic        stall_out, pc_src, wb_valid, wb_reg_write, mem_err;
  logic [31:0] branch_target, wb_data;
  logic [4:0]  wb_rd;
  int          n_tests = 0;
  int          n_fail  = 0;

  mem_stage_if #(.DATA_W(32)) dmem_if ();

  mem_stage #(.DATA_W(32), .REG_W(5), .ACK_TIMEOUT(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .i_ex_valid         (ex_valid),
    .i_ex_alu_out       (ex_alu_out),
    .i_ex_write_data    (ex_write_data),
    .i_ex_rd            (ex_rd),
    .i_ex_branch        (ex_branch),
    .i_ex_branch_target (ex_branch_target),
    .i_ex_mem_read      (ex_mem_read),
    .i_ex_mem_write     (ex_mem_write),
    .i_ex_reg_write     (ex_reg_write),
    .i_ex_mem_to_reg    (ex_mem_to_reg),
    .o_stall_out        (stall_out),
    .o_pc_src           (pc_src),
    .o_branch_target    (branch_target),
    .dmem               (dmem_if),
    .o_wb_valid         (wb_valid),
    .o_wb_reg_write     (wb_reg_write),
    .o_wb_rd            (wb_rd),
    .o_wb_data          (wb_data),
    .o_mem_err          (mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven for the following edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] rd, input logic br, input logic [31:0] tgt,
                          input logic mr, input logic mw, input logic rw, input logic m2r);
    ex_valid = v; ex_alu_out = alu; ex_write_data = wd; ex_rd = rd;
    ex_branch = br; ex_branch_target = tgt;
    ex_mem_read = mr; ex_mem_write = mw; ex_reg_write = rw; ex_mem_to_reg = m2r;
  endtask

  initial begin
    reset = 1'b1;
    drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    dmem_if.ack = 1'b0; dmem_if.rdata = 32'h0;

    // Reset state
    tick(); tick();
    #1;
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_rw", {31'd0, wb_reg_write}, 32'd0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_req", {31'd0, dmem_if.req}, 32'd0);
    chk("rst_addr", dmem_if.addr, 32'h0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_pc_src", {31'd0, pc_src}, 32'd0);
    chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
    reset = 1'b0;

    // ALU op: rd=5, alu=0x10
    drive_ex(1'b1, 32'h10, 32'h0, 5'd5, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("alu_stall", {31'd0, stall_out}, 32'd0);
    chk("alu_wb_early", {31'd0, wb_valid}, 32'd0);
    chk("alu_no_req", {31'd0, dmem_if.req}, 32'd0);
    tick(); #1;
    chk("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("alu_wb_rd", {27'd0, wb_rd}, 32'd5);
    chk("alu_wb_data", wb_data, 32'h10);
    chk("alu_wb_rw", {31'd0, wb_reg_write}, 32'd1);
    tick(); #1;
    chk("alu_wb_drop", {31'd0, wb_valid}, 32'd0);
    chk("alu_wb_hold", wb_data, 32'h10);

    // Load addr=0x40, ack on the third request cycle
    drive_ex(1'b1, 32'h40, 32'h0, 5'd7, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("ld_req1", {31'd0, dmem_if.req}, 32'd1);
    chk("ld_we1", {31'd0, dmem_if.we}, 32'd0);
    chk("ld_addr1", dmem_if.addr, 32'h40);
    chk("ld_stall1", {31'd0, stall_out}, 32'd1);
    tick(); #1;
    chk("ld_req2", {31'd0, dmem_if.req}, 32'd1);
    chk("ld_addr2", dmem_if.addr, 32'h40);
    chk("ld_stall2", {31'd0, stall_out}, 32'd1);
    tick();
    dmem_if.ack = 1'b1; dmem_if.rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_req3", {31'd0, dmem_if.req}, 32'd1);
    chk("ld_addr3", dmem_if.addr, 32'h40);
    chk("ld_stall3", {31'd0, stall_out}, 32'd0);
    tick();
    dmem_if.ack = 1'b0; dmem_if.rdata = 32'h0;
    #1;
    chk("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("ld_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("ld_wb_rw", {31'd0, wb_reg_write}, 32'd1);
    chk("ld_wb_rd", {27'd0, wb_rd}, 32'd7);
    chk("ld_req_off", {31'd0, dmem_if.req}, 32'd0);

    // Store addr=0x44 with immediate ack; ALU op accepted on the same edge
    drive_ex(1'b1, 32'h44, 32'h1234, 5'd3, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive_ex(1'b1, 32'h55, 32'h0, 5'd9, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    dmem_if.ack = 1'b1;
    #1;
    chk("st_req", {31'd0, dmem_if.req}, 32'd1);
    chk("st_we", {31'd0, dmem_if.we}, 32'd1);
    chk("st_addr", dmem_if.addr, 32'h44);
    chk("st_wdata", dmem_if.wdata, 32'h1234);
    chk("st_stall", {31'd0, stall_out}, 32'd0);
    tick();
    drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    dmem_if.ack = 1'b0;
    #1;
    chk("st_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("st_wb_rw", {31'd0, wb_reg_write}, 32'd0);
    chk("st_wb_rd", {27'd0, wb_rd}, 32'd3);
    chk("st_we_off", {31'd0, dmem_if.we}, 32'd0);
    chk("st_req_off", {31'd0, dmem_if.req}, 32'd0);
    tick(); #1;
    chk("b2b_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("b2b_wb_rd", {27'd0, wb_rd}, 32'd9);
    chk("b2b_wb_data", wb_data, 32'h55);
    chk("b2b_wb_rw", {31'd0, wb_reg_write}, 32'd1);

    // Branch to 0x100
    drive_ex(1'b1, 32'h0, 32'h0, 5'd0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("br_pc_src", {31'd0, pc_src}, 32'd1);
    chk("br_target", branch_target, 32'h100);
    tick(); #1;
    chk("br_pc_src_off", {31'd0, pc_src}, 32'd0);

    // Ack while idle is ignored
    dmem_if.ack = 1'b1;
    tick();
    dmem_if.ack = 1'b0;
    #1;
    chk("idle_ack_wb", {31'd0, wb_valid}, 32'd0);

    // Timeout: load at 0x80, never acked
    drive_ex(1'b1, 32'h80, 32'h0, 5'd4, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("to_req1", {31'd0, dmem_if.req}, 32'd1);
    chk("to_err1", {31'd0, mem_err}, 32'd0);
    tick(); #1;
    chk("to_req2", {31'd0, dmem_if.req}, 32'd1);
    tick(); #1;
    chk("to_req3", {31'd0, dmem_if.req}, 32'd1);
    tick(); #1;
    chk("to_req4", {31'd0, dmem_if.req}, 32'd1);
    chk("to_stall4", {31'd0, stall_out}, 32'd1);
    tick(); #1;
    chk("to_req_drop", {31'd0, dmem_if.req}, 32'd0);
    chk("to_err", {31'd0, mem_err}, 32'd1);
    chk("to_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("to_wb_rw", {31'd0, wb_reg_write}, 32'd0);
    chk("to_stall_rel", {31'd0, stall_out}, 32'd0);
    tick(); #1;
    chk("to_err_pulse", {31'd0, mem_err}, 32'd0);
    chk("to_wb_drop", {31'd0, wb_valid}, 32'd0);

    // Reset during an access; the late ack must be ignored
    drive_ex(1'b1, 32'h90, 32'h0, 5'd6, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rma_req", {31'd0, dmem_if.req}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dmem_if.ack = 1'b1; dmem_if.rdata = 32'hCAFE;
    #1;
    chk("rma_req_off", {31'd0, dmem_if.req}, 32'd0);
    chk("rma_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rma_stall", {31'd0, stall_out}, 32'd0);
    tick();
    dmem_if.ack = 1'b0;
    #1;
    chk("rma_late_ack", {31'd0, wb_valid}, 32'd0);
    chk("rma_wb_data", wb_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
